nrzi_bitstuff: RTL and testbench
================================

Name: nrzi_bitstuff

Overview:
Downstream stage of the USB transmit encoder. It consumes the serial bitstream produced by the packet-to-serial/CRC stage: SYNC, PID, payload and CRC, supplied LSB-first by upstream. It applies USB bit stuffing and NRZI encoding, then appends EOP (SE0, SE0, J). It drives the dp/dm line pair, one bit per clk cycle.

Parameters:
STUFF_LEN, 6, number of consecutive 1s after which a 0 is inserted.
EOP_SE0_CYCLES, 2, number of SE0 bit times in EOP.

Ports:
clk  input  1  bit-rate clock; single clock domain.
rst_b  input  1  asynchronous active-low reset.
bstr  input  1  serial data bit from upstream encoder.
bstr_valid  input  1  bstr holds a valid bit.
bstr_last  input  1  qualifies bstr as the final bit of the packet.
bstr_ready  output  1  block accepts bstr this cycle.
dp  output  1  USB D+ line.
dm  output  1  USB D- line.
tx_active  output  1  high from first driven bit through the EOP J cycle.
pkt_done  output  1  one-cycle pulse on return to IDLE after EOP.
underrun  output  1  one-cycle pulse when bstr_valid drops mid-packet.

Behaviour:
- Reset (async, rst_b=0): state=IDLE, dp=1, dm=0 (J), tx_active=0, pkt_done=0, underrun=0, ones count=0, NRZI level=J. Reset mid-packet aborts immediately; no EOP is sent.
- Transfer rule: a bit is accepted when bstr_valid && bstr_ready.
  - bstr_ready=1 in IDLE and SEND.
  - bstr_ready=0 in STUFF and all EOP states.
- All outputs are registered. A bit accepted in cycle N appears on dp/dm in cycle N+1.
- NRZI encoding:
  - bit 0 toggles the level; bit 1 holds it.
  - The level starts at J on every packet.
  - In data states, dp=level and dm=~level (J: dp=1, dm=0; K: dp=0, dm=1).
- Bit stuffing:
  - The ones counter (3 bits) increments on each accepted 1 and clears on each accepted 0.
  - When an accepted 1 brings the counter to STUFF_LEN, the next cycle is STUFF. STUFF drives a toggle (stuffed 0), clears the counter, and holds bstr_ready=0.
  - The counter clears in IDLE.
  - SYNC bits count toward the run.
- FSM states and transitions:
  - IDLE: drives J, tx_active=0. An accepted bit goes to SEND (or STUFF if it completes a run). tx_active=1 from the next cycle.
  - SEND: each accepted bit is driven next cycle.
  - After an accepted bit with bstr_last=1: go to STUFF if a stuff is pending, else EOP_SE0.
  - STUFF: one cycle. Returns to SEND, or to EOP_SE0 if the triggering bit had bstr_last=1.
  - Stuffing is mandatory even after the final bit.
  - EOP_SE0: dp=dm=0 for EOP_SE0_CYCLES cycles, then EOP_J.
  - EOP_J: one cycle of J, tx_active=1, then IDLE.
  - On entering IDLE after EOP, pkt_done=1 for one cycle.
- Underrun: in SEND with bstr_valid=0 (and no pending last), pulse underrun, then go directly to EOP_SE0 (truncated packet) and complete EOP normally. pkt_done still pulses.
- Simultaneous events: bstr_last on the bit that completes a six-1 run produces the stuff bit, then EOP. Back-to-back packets: a new bit is accepted only in IDLE, so there is a minimum of one IDLE J cycle between packets.

Decomposition:
- Shared package (usb_pkg): line-state constants J, K, SE0 as 2-bit {dp,dm}; typedef enum for tx FSM states {IDLE, SEND, STUFF, EOP_SE0, EOP_J}; STUFF_LEN default.
- One natural sub-module: bit_stuffer. It holds the ones counter and stuff_req output, with inputs bit, accept and clear.
- FSM, NRZI level register and dp/dm drive stay in the top module.

Test Plan:
- SYNC 00000001 with bstr_last on the final bit -> dp = 0,1,0,1,0,1,0,0 (KJKJKJKK); then dp=dm=0 for 2 cycles; then dp=1, dm=0 one cycle; pkt_done pulses; tx_active high for exactly 11 cycles.
- SYNC followed by 1111111 then 0 (last) -> after the 6th accepted 1 (counting SYNC's final 1, after the 5th data 1), bstr_ready=0 for one cycle and the line toggles. Total driven data bits = 8 + 8 + 1 stuff.
- Packet ending in six 1s with bstr_last on the 6th -> stuff toggle is driven, then SE0 SE0 J. Stuff precedes EOP.
- Mid-packet, bstr_valid deasserted for one cycle -> underrun pulse, SE0 SE0 J follows, pkt_done pulses, block returns to IDLE accepting a new packet.
- rst_b asserted during the 3rd payload bit -> dp=1, dm=0, tx_active=0 immediately (asynchronous). After release, a new SYNC encodes from level J.
- Two packets offered back-to-back -> bstr_ready is low through EOP, and one IDLE J cycle separates the packets.

Source files
------------

// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared USB transmit line states, FSM states and defaults
package usb_pkg;

    // Line states as {dp, dm}
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    localparam int STUFF_LEN_DEFAULT      = 6;
    localparam int EOP_SE0_CYCLES_DEFAULT = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_STUFF,
        ST_EOP_SE0,
        ST_EOP_J
    } tx_state_e;

    function automatic logic [1:0] line_for_level(input logic level);
        return level ? LINE_J : LINE_K;
    endfunction

endpackage

// File: rtl/bit_stuffer.sv
// rtl/bit_stuffer.sv - consecutive-ones counter that requests a stuffed zero
module bit_stuffer
    import usb_pkg::*;
#(
    parameter int STUFF_LEN = STUFF_LEN_DEFAULT
) (
    input  logic clk,
    input  logic rst_b,
    input  logic bit_in,
    input  logic accept,
    input  logic clear,
    output logic stuff_req
);

    logic [2:0] ones_q;
    logic [2:0] ones_d;
    logic [2:0] base;

    // clear takes effect before an accepted bit, so the first bit of a packet counts from zero
    always_comb begin
        base      = clear ? 3'd0 : ones_q;
        ones_d    = base;
        stuff_req = 1'b0;
        if (accept) begin
            if (bit_in) begin
                ones_d    = base + 3'd1;
                stuff_req = (base == 3'(STUFF_LEN - 1));
            end else begin
                ones_d = 3'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            ones_q <= 3'd0;
        end else begin
            ones_q <= ones_d;
        end
    end

endmodule

// File: rtl/nrzi_bitstuff.sv
// rtl/nrzi_bitstuff.sv - USB transmit bit stuffing, NRZI encoding and EOP generation
module nrzi_bitstuff
    import usb_pkg::*;
#(
    parameter int STUFF_LEN      = STUFF_LEN_DEFAULT,
    parameter int EOP_SE0_CYCLES = EOP_SE0_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_b,
    input  logic bstr,
    input  logic bstr_valid,
    input  logic bstr_last,
    output logic bstr_ready,
    output logic dp,
    output logic dm,
    output logic tx_active,
    output logic pkt_done,
    output logic underrun
);

    tx_state_e  state_q, state_d;
    logic       level_q, level_d;
    logic [1:0] line_q, line_d;
    logic       tx_active_q, tx_active_d;
    logic       pkt_done_q, pkt_done_d;
    logic       underrun_q, underrun_d;
    logic       ready_q, ready_d;
    logic       last_q, last_d;
    logic [3:0] se0_cnt_q, se0_cnt_d;

    logic accept;
    logic take_bit;
    logic stuff_req;
    logic stuff_clear;
    logic level_base;
    logic data_level;

    assign accept     = bstr_valid && ready_q;
    assign level_base = (state_q == ST_IDLE) ? 1'b1 : level_q;
    assign data_level = bstr ? level_base : ~level_base;

    bit_stuffer #(
        .STUFF_LEN(STUFF_LEN)
    ) u_stuffer (
        .clk      (clk),
        .rst_b    (rst_b),
        .bit_in   (bstr),
        .accept   (accept),
        .clear    (stuff_clear),
        .stuff_req(stuff_req)
    );

    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        line_d      = line_for_level(level_q);
        tx_active_d = 1'b1;
        pkt_done_d  = 1'b0;
        underrun_d  = 1'b0;
        last_d      = last_q;
        se0_cnt_d   = se0_cnt_q;
        stuff_clear = 1'b1;
        take_bit    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                level_d     = 1'b1;
                line_d      = LINE_J;
                tx_active_d = 1'b0;
                take_bit    = accept;
            end
            ST_SEND: begin
                stuff_clear = 1'b0;
                if (accept) begin
                    take_bit = 1'b1;
                end else begin
                    // Truncated packet: the first SE0 goes out now
                    line_d     = LINE_SE0;
                    underrun_d = 1'b1;
                    se0_cnt_d  = 4'd1;
                    state_d    = (EOP_SE0_CYCLES > 1) ? ST_EOP_SE0 : ST_EOP_J;
                end
            end
            ST_STUFF: begin
                level_d   = ~level_q;
                line_d    = line_for_level(~level_q);
                se0_cnt_d = 4'd0;
                state_d   = last_q ? ST_EOP_SE0 : ST_SEND;
            end
            ST_EOP_SE0: begin
                line_d = LINE_SE0;
                if (se0_cnt_q == 4'(EOP_SE0_CYCLES - 1)) begin
                    state_d = ST_EOP_J;
                end else begin
                    se0_cnt_d = se0_cnt_q + 4'd1;
                end
            end
            ST_EOP_J: begin
                level_d    = 1'b1;
                line_d     = LINE_J;
                pkt_done_d = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (take_bit) begin
            level_d     = data_level;
            line_d      = line_for_level(data_level);
            tx_active_d = 1'b1;
            last_d      = bstr_last;
            se0_cnt_d   = 4'd0;
            if (stuff_req) begin
                state_d = ST_STUFF;
            end else if (bstr_last) begin
                state_d = ST_EOP_SE0;
            end else begin
                state_d = ST_SEND;
            end
        end

        ready_d = (state_d == ST_IDLE) || (state_d == ST_SEND);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= ST_IDLE;
            level_q     <= 1'b1;
            line_q      <= LINE_J;
            tx_active_q <= 1'b0;
            pkt_done_q  <= 1'b0;
            underrun_q  <= 1'b0;
            ready_q     <= 1'b1;
            last_q      <= 1'b0;
            se0_cnt_q   <= 4'd0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            line_q      <= line_d;
            tx_active_q <= tx_active_d;
            pkt_done_q  <= pkt_done_d;
            underrun_q  <= underrun_d;
            ready_q     <= ready_d;
            last_q      <= last_d;
            se0_cnt_q   <= se0_cnt_d;
        end
    end

    assign bstr_ready = ready_q;
    assign dp         = line_q[1];
    assign dm         = line_q[0];
    assign tx_active  = tx_active_q;
    assign pkt_done   = pkt_done_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_nrzi_bitstuff.sv
// tb/tb_nrzi_bitstuff.sv - self-checking bench for nrzi_bitstuff
module tb_nrzi_bitstuff;

    logic clk = 1'b0;
    logic rst_b;
    logic bstr;
    logic bstr_valid;
    logic bstr_last;
    logic bstr_ready;
    logic dp;
    logic dm;
    logic tx_active;
    logic pkt_done;
    logic underrun;

    nrzi_bitstuff dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .bstr      (bstr),
        .bstr_valid(bstr_valid),
        .bstr_last (bstr_last),
        .bstr_ready(bstr_ready),
        .dp        (dp),
        .dm        (dm),
        .tx_active (tx_active),
        .pkt_done  (pkt_done),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic dp;
        logic dm;
        logic txa;
        logic done;
        logic und;
        logic chk_rdy;
        logic rdy;
    } exp_t;

    typedef struct {
        logic [31:0] bits;
        int          n;
        logic [31:0] exp_dp;
        int          exp_n;
        int          exp_stuffs;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[5];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", name, got, exp);
    endtask

    task automatic push_exp(input logic e_dp, input logic e_dm, input logic e_txa,
                            input logic e_done, input logic e_und, input logic e_chk,
                            input logic e_rdy);
        exp_t e;
        e.dp = e_dp; e.dm = e_dm; e.txa = e_txa; e.done = e_done;
        e.und = e_und; e.chk_rdy = e_chk; e.rdy = e_rdy;
        exp_q.push_back(e);
    endtask

    task automatic check_front(input string name, input int idx);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL %s[%0d] no expectation left for output cycle", name, idx);
        end else begin
            e = exp_q.pop_front();
            check($sformatf("%s[%0d] {dp,dm,txa,done,und}", name, idx),
                  {27'd0, dp, dm, tx_active, pkt_done, underrun},
                  {27'd0, e.dp, e.dm, e.txa, e.done, e.und});
            if (e.chk_rdy)
                check($sformatf("%s[%0d] ready", name, idx), {31'd0, bstr_ready}, {31'd0, e.rdy});
        end
    endtask

    // Offers bits until all are accepted; expected line = hand-derived data line + SE0 SE0 J (+ idle J)
    task automatic run_pkt(input string name, input logic [31:0] bits, input int n,
                           input bit with_last, input int exp_n, input logic [31:0] exp_dp,
                           input int exp_stuffs, input bit b2b, input logic nb);
        int   i;
        int   stalls;
        int   guard;
        int   idx;
        logic rdy_now;
        exp_q.delete();
        for (int j = 0; j < exp_n; j++) push_exp(exp_dp[j], ~exp_dp[j], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push_exp(1'b0, 1'b0, 1'b1, 1'b0, !with_last, 1'b1, 1'b0);
        push_exp(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        push_exp(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        if (!b2b) push_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        i = 0; stalls = 0; guard = 0; idx = 0;
        while (i < n && guard < 4 * n + 8) begin
            bstr       = bits[i];
            bstr_valid = 1'b1;
            bstr_last  = with_last && (i == n - 1);
            rdy_now    = bstr_ready;
            @(negedge clk);
            check_front(name, idx);
            idx++;
            if (rdy_now) i++;
            else stalls++;
            guard++;
        end
        if (i < n) begin
            n_checks++;
            $display("FAIL %s accept timeout accepted=%0d required=%0d", name, i, n);
        end
        check({name, " stall cycles"}, stalls, exp_stuffs);
        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            bstr_last = 1'b0;
            if (b2b) begin
                bstr       = nb;
                bstr_valid = 1'b1;
            end else begin
                bstr_valid = 1'b0;
            end
            @(negedge clk);
            check_front(name, idx);
            idx++;
            guard++;
        end
        bstr_valid = b2b;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rbits;

        vecs[0] = '{bits: 32'h0000_0080, n: 8,  exp_dp: 32'h0000_002A, exp_n: 8,  exp_stuffs: 0};
        vecs[1] = '{bits: 32'h0000_7F80, n: 16, exp_dp: 32'h0000_E02A, exp_n: 17, exp_stuffs: 1};
        vecs[2] = '{bits: 32'h0000_7E80, n: 15, exp_dp: 32'h0000_7F2A, exp_n: 16, exp_stuffs: 0};
        vecs[3] = '{bits: 32'h0000_A380, n: 16, exp_dp: 32'h0000_342A, exp_n: 16, exp_stuffs: 0};
        vecs[4] = '{bits: 32'h0000_00FF, n: 8,  exp_dp: 32'h0000_003F, exp_n: 9,  exp_stuffs: 1};

        rst_b      = 1'b0;
        bstr       = 1'b0;
        bstr_valid = 1'b0;
        bstr_last  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset {dp,dm,txa,done,und,rdy}",
              {26'd0, dp, dm, tx_active, pkt_done, underrun, bstr_ready}, 32'b100001);
        rst_b = 1'b1;
        @(negedge clk);
        check("idle {dp,dm,txa,rdy}", {28'd0, dp, dm, tx_active, bstr_ready}, 32'b1001);

        for (int v = 0; v < 5; v++)
            run_pkt($sformatf("vec%0d", v), vecs[v].bits, vecs[v].n, 1'b1, vecs[v].exp_n,
                    vecs[v].exp_dp, vecs[v].exp_stuffs, 1'b0, 1'b0);

        // SYNC with no last, then valid drops: underrun and truncated EOP
        run_pkt("underrun", 32'h80, 8, 1'b0, 8, 32'h2A, 0, 1'b0, 1'b0);
        run_pkt("after_underrun", vecs[0].bits, 8, 1'b1, 8, vecs[0].exp_dp, 0, 1'b0, 1'b0);

        // Second packet offered during the first one's EOP
        run_pkt("b2b_a", vecs[0].bits, 8, 1'b1, 8, vecs[0].exp_dp, 0, 1'b1, vecs[3].bits[0]);
        run_pkt("b2b_b", vecs[3].bits, vecs[3].n, 1'b1, vecs[3].exp_n, vecs[3].exp_dp, 0,
                1'b0, 1'b0);

        // Asynchronous reset while the third payload bit is offered
        rbits = 32'h0000_0080;
        for (int k = 0; k < 10; k++) begin
            bstr       = rbits[k];
            bstr_valid = 1'b1;
            bstr_last  = 1'b0;
            @(negedge clk);
        end
        bstr = rbits[10];
        check("pre_reset {dp,txa}", {30'd0, dp, tx_active}, 32'b01);
        #2 rst_b = 1'b0;
        #1 check("async_reset {dp,dm,txa,done,und,rdy}",
                 {26'd0, dp, dm, tx_active, pkt_done, underrun, bstr_ready}, 32'b100001);
        bstr_valid = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        run_pkt("after_reset", vecs[0].bits, 8, 1'b1, 8, vecs[0].exp_dp, 0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
